// File: rtl/gimli_hash_driver_if.sv
// Signal bundle between gimli_hash_driver and its surroundings: the message
// source, one gimli_rounds_simple core, and the digest consumer.
// The master modport is the driver's view. The slave modport is the
// environment's view.
interface gimli_hash_driver_if;
    // Message word stream into the driver
    logic [127:0] msg_din;
    logic [4:0]   msg_din_size;
    logic         msg_din_last;
    logic         msg_din_valid;
    logic         msg_din_ready;
    // Command stream from the driver to the core
    logic [2:0]   core_oper;
    logic [127:0] core_din;
    logic [4:0]   core_din_size;
    logic         core_din_valid;
    logic         core_din_ready;
    // Squeeze data from the core
    logic [127:0] core_dout;
    logic [4:0]   core_dout_size;
    logic         core_dout_valid;
    logic         core_dout_ready;
    // Digest beats to the consumer
    logic [127:0] hash_dout;
    logic         hash_dout_valid;
    logic         hash_dout_last;
    logic         hash_dout_ready;

    modport master (
        input  msg_din, msg_din_size, msg_din_last, msg_din_valid,
        output msg_din_ready,
        output core_oper, core_din, core_din_size, core_din_valid,
        input  core_din_ready,
        input  core_dout, core_dout_size, core_dout_valid,
        output core_dout_ready,
        output hash_dout, hash_dout_valid, hash_dout_last,
        input  hash_dout_ready
    );

    modport slave (
        output msg_din, msg_din_size, msg_din_last, msg_din_valid,
        input  msg_din_ready,
        input  core_oper, core_din, core_din_size, core_din_valid,
        output core_din_ready,
        output core_dout, core_dout_size, core_dout_valid,
        input  core_dout_ready,
        input  hash_dout, hash_dout_valid, hash_dout_last,
        output hash_dout_ready
    );
endinterface

// File: rtl/gimli_hash_driver.sv
// Gimli-Hash command initiator. It turns a 128-bit message word stream into
// the core command sequence: zero init, absorb, optional empty pad block, and
// squeezes. It forwards the core's squeeze output as DIGEST_BEATS digest beats.
module gimli_hash_driver #(
    parameter int DIGEST_BEATS = 2
) (
    input  logic                       clk,
    input  logic                       arstn,
    gimli_hash_driver_if.master        bus,
    output logic                       busy
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_INIT2,
        S_ABSORB,
        S_PAD,
        S_SQZ,
        S_SQZL,
        S_DRAIN
    } state_t;

    localparam logic [2:0] OP_ABSORB = 3'b000;
    localparam logic [2:0] OP_SQZ    = 3'b011;
    localparam logic [2:0] OP_INIT0  = 3'b100;
    localparam logic [2:0] OP_INIT1  = 3'b101;
    localparam logic [2:0] OP_INIT2  = 3'b110;
    localparam logic [2:0] OP_SQZL   = 3'b111;

    localparam logic [3:0] LAST_BEAT = 4'(DIGEST_BEATS - 1);
    // A single-beat digest needs no plain squeeze and goes straight to the final one.
    localparam state_t SQZ_FIRST = (DIGEST_BEATS == 1) ? S_SQZL : S_SQZ;

    state_t     state;
    state_t     state_next;
    logic [3:0] beat_cnt;
    logic [3:0] out_cnt;
    logic       cmd_fire;
    logic       hash_fire;
    logic       drain_done;
    logic       unused_dout_size;

    assign cmd_fire   = bus.core_din_valid && bus.core_din_ready;
    assign hash_fire  = bus.hash_dout_valid && bus.hash_dout_ready;
    assign drain_done = hash_fire && bus.hash_dout_last;

    // The core reports a size on its output, but every digest beat is a full 128 bits.
    assign unused_dout_size = ^bus.core_dout_size;

    // State register; a reset aborts any hash in progress.
    always_ff @(posedge clk) begin
        // NOTE: Sequential state uses non-blocking assignments so that every
        // register samples values from before the edge. This keeps the update
        // independent of the order in which the processes run.
        if (arstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Squeeze counter and digest beat counter; they advance independently.
    always_ff @(posedge clk) begin
        if (arstn) begin
            beat_cnt <= 4'd0;
            out_cnt  <= 4'd0;
        end else begin
            if (state == S_DRAIN && drain_done) begin
                beat_cnt <= 4'd0;
            end else if (state == S_SQZ && cmd_fire) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
            if (hash_fire) begin
                out_cnt <= bus.hash_dout_last ? 4'd0 : out_cnt + 4'd1;
            end
        end
    end

    // Next-state logic: every command state advances only when the core accepts the command.
    always_comb begin
        // NOTE: Holding the current state as a default covers every path
        // through the case. This keeps the block purely combinational, so no
        // latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:   if (bus.msg_din_valid) state_next = S_INIT0;
            S_INIT0:  if (cmd_fire) state_next = S_INIT1;
            S_INIT1:  if (cmd_fire) state_next = S_INIT2;
            S_INIT2:  if (cmd_fire) state_next = S_ABSORB;
            S_ABSORB: begin
                if (cmd_fire && bus.msg_din_last) begin
                    state_next = (bus.msg_din_size == 5'd16) ? S_PAD : SQZ_FIRST;
                end
            end
            S_PAD:    if (cmd_fire) state_next = SQZ_FIRST;
            S_SQZ: begin
                if (cmd_fire && (beat_cnt + 4'd1) == LAST_BEAT) state_next = S_SQZL;
            end
            S_SQZL:   if (cmd_fire) state_next = S_DRAIN;
            S_DRAIN:  if (drain_done) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Command outputs decoded from the state; the absorb state passes the message stream through.
    always_comb begin
        bus.core_oper      = OP_ABSORB;
        bus.core_din       = '0;
        bus.core_din_size  = 5'd16;
        bus.core_din_valid = 1'b0;
        bus.msg_din_ready  = 1'b0;
        case (state)
            S_INIT0: begin
                bus.core_oper      = OP_INIT0;
                bus.core_din_valid = 1'b1;
            end
            S_INIT1: begin
                bus.core_oper      = OP_INIT1;
                bus.core_din_valid = 1'b1;
            end
            S_INIT2: begin
                bus.core_oper      = OP_INIT2;
                bus.core_din_valid = 1'b1;
            end
            S_ABSORB: begin
                bus.core_din       = bus.msg_din;
                bus.core_din_size  = bus.msg_din_last ? bus.msg_din_size : 5'd16;
                bus.core_din_valid = bus.msg_din_valid;
                bus.msg_din_ready  = bus.core_din_ready;
            end
            S_PAD: begin
                bus.core_din_size  = 5'd0;
                bus.core_din_valid = 1'b1;
            end
            S_SQZ: begin
                bus.core_oper      = OP_SQZ;
                bus.core_din_valid = 1'b1;
            end
            S_SQZL: begin
                bus.core_oper      = OP_SQZL;
                bus.core_din_valid = 1'b1;
            end
            default: begin
                bus.core_din_valid = 1'b0;
            end
        endcase
    end

    // The digest path is a straight pass-through of the core output.
    assign bus.hash_dout       = bus.core_dout;
    assign bus.hash_dout_valid = bus.core_dout_valid;
    assign bus.core_dout_ready = bus.hash_dout_ready;
    assign bus.hash_dout_last  = (out_cnt == LAST_BEAT);
    assign busy                = (state != S_IDLE);

endmodule

// File: tb/tb_gimli_hash_driver.sv
// Bench for gimli_hash_driver. A behavioural stand-in for the core accepts
// commands with random readiness and produces squeeze data from a simple
// mixing function. A reference model builds the expected command list and
// digest directly from the message.
module tb_gimli_hash_driver;
    localparam int DB      = 2;
    localparam int TIMEOUT = 3000;

    typedef struct packed {
        logic [2:0]   oper;
        logic [127:0] din;
        logic [4:0]   size;
    } cmd_t;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic arstn = 1'b1;
    logic busy;

    gimli_hash_driver_if bus();

    gimli_hash_driver #(.DIGEST_BEATS(DB)) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    cmd_t         cmd_log[$];
    beat_t        beat_log[$];
    logic [127:0] msg_q[$];
    logic         hold_low = 1'b0;
    logic         watch_111 = 1'b0;
    int           early_111 = 0;
    logic         rdy_rand;
    logic [127:0] core_st;

    function automatic logic is_sqz(logic [2:0] oper);
        return (oper == 3'b011) || (oper == 3'b111);
    endfunction

    // Stand-in core permutation: init0 restarts from zero, squeezes ignore din/size.
    function automatic logic [127:0] mix(logic [127:0] st, cmd_t c);
        logic [127:0] base;
        logic [127:0] d;
        logic [4:0]   sz;
        base = (c.oper == 3'b100) ? 128'h0 : st;
        d    = is_sqz(c.oper) ? 128'h0 : c.din;
        sz   = is_sqz(c.oper) ? 5'd0 : c.size;
        return {base[118:0], base[127:119]} ^ {base[40:0], base[127:41]} ^ d ^
               {120'h0, c.oper, sz} ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core stand-in: it refuses commands while an unconsumed output is being back-pressured.
    assign bus.core_din_ready = rdy_rand && !(bus.core_dout_valid && !bus.core_dout_ready);
    assign bus.core_dout_size = 5'd16;

    always @(posedge clk) begin
        if (arstn) begin
            rdy_rand            <= 1'b0;
            core_st             <= '0;
            bus.core_dout_valid <= 1'b0;
            bus.core_dout       <= '0;
        end else begin
            rdy_rand <= ($urandom_range(0, 3) != 0);
            if (bus.core_dout_valid && bus.core_dout_ready) bus.core_dout_valid <= 1'b0;
            if (bus.core_din_valid && bus.core_din_ready) begin
                core_st <= mix(core_st, cmd_t'{bus.core_oper, bus.core_din, bus.core_din_size});
                if (is_sqz(bus.core_oper)) begin
                    bus.core_dout       <= mix(core_st, cmd_t'{bus.core_oper, bus.core_din, bus.core_din_size});
                    bus.core_dout_valid <= 1'b1;
                end
            end
        end
    end

    // Monitor: log accepted commands and digest beats away from the active edge.
    always @(negedge clk) begin
        if (!arstn) begin
            if (bus.core_din_valid && bus.core_din_ready) begin
                cmd_log.push_back(cmd_t'{bus.core_oper, bus.core_din, bus.core_din_size});
                if (watch_111 && bus.core_oper == 3'b111) early_111 <= early_111 + 1;
            end
            if (bus.hash_dout_valid && bus.hash_dout_ready) begin
                beat_log.push_back(beat_t'{bus.hash_dout, bus.hash_dout_last});
            end
        end
    end

    // Digest consumer: random readiness unless a stall is being held.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.hash_dout_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Runs one hash of msg_q and checks the command stream and the digest against the reference.
    task automatic do_hash(input string name, input logic [4:0] last_size, input bit stall,
                           output logic [DB*128-1:0] digest);
        cmd_t         exp_cmds[$];
        logic [127:0] exp_beats[$];
        logic [127:0] st;
        int           t;
        bit           to;
        int           n;
        logic         is_last;

        exp_cmds = {};
        exp_beats = {};
        exp_cmds.push_back(cmd_t'{3'b100, 128'h0, 5'd16});
        exp_cmds.push_back(cmd_t'{3'b101, 128'h0, 5'd16});
        exp_cmds.push_back(cmd_t'{3'b110, 128'h0, 5'd16});
        for (int w = 0; w < msg_q.size(); w++) begin
            exp_cmds.push_back(cmd_t'{3'b000, msg_q[w], (w == msg_q.size() - 1) ? last_size : 5'd16});
        end
        if (last_size == 5'd16) exp_cmds.push_back(cmd_t'{3'b000, 128'h0, 5'd0});
        for (int b = 0; b < DB - 1; b++) exp_cmds.push_back(cmd_t'{3'b011, 128'h0, 5'd0});
        exp_cmds.push_back(cmd_t'{3'b111, 128'h0, 5'd0});
        st = '0;
        foreach (exp_cmds[i]) begin
            st = mix(st, exp_cmds[i]);
            if (is_sqz(exp_cmds[i].oper)) exp_beats.push_back(st);
        end

        cmd_log.delete();
        beat_log.delete();
        hold_low = stall;
        watch_111 = stall;
        early_111 = 0;
        to = 1'b0;

        for (int w = 0; w < msg_q.size(); w++) begin
            @(posedge clk);
            #1;
            is_last = (w == msg_q.size() - 1);
            bus.msg_din       = msg_q[w];
            bus.msg_din_last  = is_last;
            bus.msg_din_size  = is_last ? last_size : 5'($urandom_range(0, 16));
            bus.msg_din_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.msg_din_ready && t < TIMEOUT);
            @(posedge clk);
            #1;
            bus.msg_din_valid = 1'b0;
            if (t >= TIMEOUT) begin
                to = 1'b1;
                break;
            end
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end

        if (stall) begin
            t = 0;
            while (!bus.core_dout_valid && t < TIMEOUT) begin
                @(negedge clk);
                t++;
            end
            if (t >= TIMEOUT) to = 1'b1;
            repeat (50) @(negedge clk);
            vectors++;
            if (early_111 !== 0) begin
                miscompares++;
                $display("FAIL %s stall_sqzl: final squeeze accepted %0d times during stall, want 0", name, early_111);
            end
            vectors++;
            if (beat_log.size() !== 0) begin
                miscompares++;
                $display("FAIL %s stall_beats: %0d beats during stall, want 0", name, beat_log.size());
            end
            hold_low = 1'b0;
            watch_111 = 1'b0;
        end

        t = 0;
        while (!(beat_log.size() == DB && !busy) && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (to || t >= TIMEOUT) begin
            miscompares++;
            $display("FAIL %s timeout: beats %0d busy %b, want %0d beats and idle", name, beat_log.size(), busy, DB);
        end

        vectors++;
        if (cmd_log.size() !== exp_cmds.size()) begin
            miscompares++;
            $display("FAIL %s cmd_count: got %0d want %0d", name, cmd_log.size(), exp_cmds.size());
        end
        n = (cmd_log.size() < exp_cmds.size()) ? cmd_log.size() : exp_cmds.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (cmd_log[i].oper !== exp_cmds[i].oper) begin
                miscompares++;
                $display("FAIL %s cmd[%0d].oper: got %b want %b", name, i, cmd_log[i].oper, exp_cmds[i].oper);
            end
            if (!is_sqz(exp_cmds[i].oper)) begin
                vectors++;
                if ({cmd_log[i].din, cmd_log[i].size} !== {exp_cmds[i].din, exp_cmds[i].size}) begin
                    miscompares++;
                    $display("FAIL %s cmd[%0d].din/size: got %h/%0d want %h/%0d", name, i,
                             cmd_log[i].din, cmd_log[i].size, exp_cmds[i].din, exp_cmds[i].size);
                end
            end
        end

        vectors++;
        if (beat_log.size() !== DB) begin
            miscompares++;
            $display("FAIL %s beat_count: got %0d want %0d", name, beat_log.size(), DB);
        end
        digest = '0;
        for (int i = 0; i < DB && i < beat_log.size(); i++) begin
            digest[i*128 +: 128] = beat_log[i].data;
            vectors++;
            if (beat_log[i].data !== exp_beats[i]) begin
                miscompares++;
                $display("FAIL %s beat[%0d].data: got %h want %h", name, i, beat_log[i].data, exp_beats[i]);
            end
            vectors++;
            if (beat_log[i].last !== (i == DB - 1)) begin
                miscompares++;
                $display("FAIL %s beat[%0d].last: got %b want %b", name, i, beat_log[i].last, (i == DB - 1));
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_end: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        string      names[5];
        names = '{"busy", "msg_din_ready", "core_din_valid", "hash_dout_last", "hash_dout_valid"};
        @(posedge clk);
        #1;
        arstn = 1'b1;
        @(negedge clk);
        obs = {busy, bus.msg_din_ready, bus.core_din_valid, bus.hash_dout_last, bus.hash_dout_valid};
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (obs[4-i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_%s: got %b want 0", names[i], obs[4-i]);
            end
        end
        @(posedge clk);
        #1;
        arstn = 1'b0;
        bus.msg_din       = rand128();
        bus.msg_din_last  = 1'b1;
        bus.msg_din_size  = 5'd3;
        bus.msg_din_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.msg_din_ready, bus.core_din_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_consume: ready/valid got %b want 00", {bus.msg_din_ready, bus.core_din_valid});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({busy, bus.core_din_valid, bus.core_oper} !== {2'b11, 3'b100}) begin
            miscompares++;
            $display("FAIL init0_issue: busy/valid/oper got %b want 11100", {busy, bus.core_din_valid, bus.core_oper});
        end
        @(posedge clk);
        #1;
        arstn = 1'b1;
        bus.msg_din_valid = 1'b0;
        @(posedge clk);
        #1;
        arstn = 1'b0;
    endtask

    task automatic test_empty();
        logic [DB*128-1:0] d;
        msg_q = {rand128()};
        do_hash("empty", 5'd0, 1'b0, d);
    endtask

    task automatic test_abc();
        logic [DB*128-1:0] d;
        msg_q = {128'h636261};
        do_hash("abc", 5'd3, 1'b0, d);
    endtask

    task automatic test_full_block();
        logic [DB*128-1:0] d;
        msg_q = {rand128()};
        do_hash("full16", 5'd16, 1'b0, d);
    endtask

    task automatic test_40_bytes();
        logic [DB*128-1:0] d;
        msg_q = {rand128(), rand128(), rand128()};
        do_hash("bytes40", 5'd8, 1'b0, d);
    endtask

    task automatic test_random();
        logic [DB*128-1:0] d;
        int                nw;
        for (int k = 0; k < 6; k++) begin
            nw = $urandom_range(1, 4);
            msg_q = {};
            for (int w = 0; w < nw; w++) msg_q.push_back(rand128());
            do_hash($sformatf("random%0d", k), 5'($urandom_range(0, 16)), 1'b0, d);
        end
    endtask

    task automatic test_stall();
        logic [DB*128-1:0] d_free;
        logic [DB*128-1:0] d_stall;
        logic [4:0]        sz;
        msg_q = {rand128(), rand128()};
        sz = 5'($urandom_range(1, 15));
        do_hash("stall_ref", sz, 1'b0, d_free);
        do_hash("stall", sz, 1'b1, d_stall);
        vectors++;
        if (d_stall !== d_free) begin
            miscompares++;
            $display("FAIL stall_digest: got %h want %h", d_stall, d_free);
        end
    endtask

    task automatic test_reset_mid_hash();
        logic [DB*128-1:0] d;
        logic [3:0]        obs;
        int                t;
        cmd_log.delete();
        @(posedge clk);
        #1;
        bus.msg_din       = rand128();
        bus.msg_din_last  = 1'b0;
        bus.msg_din_size  = 5'd16;
        bus.msg_din_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.msg_din_ready && t < TIMEOUT);
        vectors++;
        if (t >= TIMEOUT) begin
            miscompares++;
            $display("FAIL midreset_first_absorb: no handshake within %0d cycles", TIMEOUT);
        end
        @(posedge clk);
        #1;
        bus.msg_din = rand128();
        @(posedge clk);
        #1;
        arstn = 1'b1;
        @(posedge clk);
        #1;
        arstn = 1'b0;
        bus.msg_din_valid = 1'b0;
        @(negedge clk);
        obs = {busy, bus.core_din_valid, bus.msg_din_ready, bus.hash_dout_valid};
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_idle: busy/core_valid/msg_ready/hash_valid got %b want 0000", obs);
        end
        msg_q = {128'h636261};
        do_hash("abc_after_reset", 5'd3, 1'b0, d);
    endtask

    initial begin
        bus.msg_din       = '0;
        bus.msg_din_size  = 5'd0;
        bus.msg_din_last  = 1'b0;
        bus.msg_din_valid = 1'b0;
        arstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_full_block();
        test_40_bytes();
        test_random();
        test_stall();
        test_reset_mid_hash();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
